// File: rtl/byte_display_scanner_if.sv
// Bundle of the byte_display_scanner data, handshake and display lines.
// The master drives the value and load strobe; the slave returns status, digits and scan outputs.
interface byte_display_scanner_if;
   logic [7:0] entrada;
   logic       cargar;
   logic       ocupado;
   logic       listo;
   logic [3:0] centena;
   logic [3:0] decena;
   logic [3:0] unidad;
   logic [2:0] anodo;
   logic [6:0] segmentos;

   modport master (
      output entrada, cargar,
      input  ocupado, listo, centena, decena, unidad, anodo, segmentos
   );

   modport slave (
      input  entrada, cargar,
      output ocupado, listo, centena, decena, unidad, anodo, segmentos
   );
endinterface

// File: rtl/byte_display_scanner.sv
// Serial double-dabble conversion of a byte into three BCD digits.
// Also drives a free-running 3-digit multiplexed 7-segment scan with leading-zero blanking.
module byte_display_scanner #(
   parameter int REFRESH_DIV   = 50000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   byte_display_scanner_if.slave  bus
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  shreg_reg, shreg_next;
   logic [11:0] bcd_reg, bcd_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [3:0]  centena_reg, centena_next;
   logic [3:0]  decena_reg, decena_next;
   logic [3:0]  unidad_reg, unidad_next;
   logic        listo_reg, listo_next;
   logic [11:0] bcd_adj;
   logic [19:0] shifted;

   logic [CW-1:0] scan_cnt_reg;
   logic [1:0]    scan_idx_reg;
   logic [2:0]    anodo_reg, anodo_next;
   logic [6:0]    seg_reg, seg_next;
   logic [3:0]    sel_digit;
   logic          sel_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction on every nibble before the shift
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign shifted = {bcd_adj, shreg_reg} << 1;

   always_comb begin
      state_next   = state_reg;
      shreg_next   = shreg_reg;
      bcd_next     = bcd_reg;
      bit_cnt_next = bit_cnt_reg;
      centena_next = centena_reg;
      decena_next  = decena_reg;
      unidad_next  = unidad_reg;
      listo_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.cargar) begin
               shreg_next   = bus.entrada;
               bcd_next     = 12'd0;
               bit_cnt_next = 3'd0;
               state_next   = CONV;
            end
         end
         CONV: begin
            bcd_next     = shifted[19:8];
            shreg_next   = shifted[7:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            // Eighth shift: publish the shifted result directly
            if (bit_cnt_reg == 3'd7) begin
               centena_next = shifted[19:16];
               decena_next  = shifted[15:12];
               unidad_next  = shifted[11:8];
               listo_next   = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         shreg_reg   <= 8'd0;
         bcd_reg     <= 12'd0;
         bit_cnt_reg <= 3'd0;
         centena_reg <= 4'd0;
         decena_reg  <= 4'd0;
         unidad_reg  <= 4'd0;
         listo_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shreg_reg   <= shreg_next;
         bcd_reg     <= bcd_next;
         bit_cnt_reg <= bit_cnt_next;
         centena_reg <= centena_next;
         decena_reg  <= decena_next;
         unidad_reg  <= unidad_next;
         listo_reg   <= listo_next;
      end
   end

   always_comb begin
      sel_digit  = unidad_reg;
      sel_blank  = 1'b0;
      anodo_next = 3'b110;
      case (scan_idx_reg)
         2'd1: begin
            sel_digit  = decena_reg;
            sel_blank  = BLANK_LEADING && (centena_reg == 4'd0) && (decena_reg == 4'd0);
            anodo_next = 3'b101;
         end
         2'd2: begin
            sel_digit  = centena_reg;
            sel_blank  = BLANK_LEADING && (centena_reg == 4'd0);
            anodo_next = 3'b011;
         end
         default: begin
            sel_digit  = unidad_reg;
            sel_blank  = 1'b0;
            anodo_next = 3'b110;
         end
      endcase
      seg_next = sel_blank ? 7'b1111111 : seg_decode(sel_digit);
   end

   // Scanner is free-running and unaffected by the conversion FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_reg <= '0;
         scan_idx_reg <= 2'd0;
         anodo_reg    <= 3'b110;
         seg_reg      <= 7'b1000000;
      end else begin
         if (scan_cnt_reg == CW'(REFRESH_DIV - 1)) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= (scan_idx_reg == 2'd2) ? 2'd0 : scan_idx_reg + 2'd1;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + CW'(1);
         end
         anodo_reg <= anodo_next;
         seg_reg   <= seg_next;
      end
   end

   assign bus.ocupado   = (state_reg == CONV);
   assign bus.listo     = listo_reg;
   assign bus.centena   = centena_reg;
   assign bus.decena    = decena_reg;
   assign bus.unidad    = unidad_reg;
   assign bus.anodo     = anodo_reg;
   assign bus.segmentos = seg_reg;

endmodule

// File: tb/tb_byte_display_scanner.sv
// Randomized self-checking bench for byte_display_scanner against a decimal-arithmetic model.
// Also checks the scan sequence, per-digit segment patterns and digit hold times.
module tb_byte_display_scanner;
   localparam int RD = 4;

   logic clk;
   logic rst;
   byte_display_scanner_if bus ();

   byte_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int exp_c, exp_d, exp_u;
   logic [6:0] seg_tab [0:9];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [2:0] an);
      case (an)
         3'b110:  exp_seg = seg_tab[exp_u];
         3'b101:  exp_seg = (exp_c == 0 && exp_d == 0) ? 7'b1111111 : seg_tab[exp_d];
         3'b011:  exp_seg = (exp_c == 0) ? 7'b1111111 : seg_tab[exp_c];
         default: exp_seg = 7'bxxxxxxx;
      endcase
   endfunction

   function automatic logic [2:0] next_anodo(input logic [2:0] an);
      case (an)
         3'b110:  next_anodo = 3'b101;
         3'b101:  next_anodo = 3'b011;
         default: next_anodo = 3'b110;
      endcase
   endfunction

   function automatic logic [11:0] exp_digits();
      exp_digits = {exp_c[3:0], exp_d[3:0], exp_u[3:0]};
   endfunction

   // Load v, optionally hammering cargar with other values while busy.
   // Entered and left right after a falling edge.
   task automatic convert(input int v, input bit inject);
      bus.entrada = v[7:0];
      bus.cargar  = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 8; k++) begin
         check("ocupado_busy", {31'd0, bus.ocupado}, 1);
         check("listo_busy", {31'd0, bus.listo}, 0);
         check("digits_hold", {20'd0, bus.centena, bus.decena, bus.unidad}, {20'd0, exp_digits()});
         bus.cargar  = inject;
         bus.entrada = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      bus.cargar = 1'b0;
      exp_c = v / 100;
      exp_d = (v / 10) % 10;
      exp_u = v % 10;
      check("listo_pulse", {31'd0, bus.listo}, 1);
      check("ocupado_done", {31'd0, bus.ocupado}, 0);
      check("digits_new", {20'd0, bus.centena, bus.decena, bus.unidad}, {20'd0, exp_digits()});
      $display("conv entrada=%0d inject=%0d -> %0d %0d %0d", v, inject, bus.centena, bus.decena, bus.unidad);
      @(negedge clk);
      check("listo_single", {31'd0, bus.listo}, 0);
   endtask

   task automatic scan_check();
      logic [2:0] prev;
      int run;
      int trans;
      bit first;
      @(negedge clk);
      prev  = bus.anodo;
      run   = 0;
      trans = 0;
      first = 1'b1;
      for (int k = 0; k < 4 * RD + 2; k++) begin
         check("anodo_onehot",
               {31'd0, (bus.anodo == 3'b110 || bus.anodo == 3'b101 || bus.anodo == 3'b011)}, 1);
         check("segmentos", {25'd0, bus.segmentos}, {25'd0, exp_seg(bus.anodo)});
         if (bus.anodo != prev) begin
            if (!first) check("run_len", run, RD);
            check("anodo_order", {29'd0, bus.anodo}, {29'd0, next_anodo(prev)});
            first = 1'b0;
            trans++;
            run  = 1;
            prev = bus.anodo;
         end else begin
            run++;
         end
         @(negedge clk);
      end
      check("scan_moved", {31'd0, trans >= 3}, 1);
      $display("scan digits=%0d%0d%0d transitions=%0d", exp_c, exp_d, exp_u, trans);
   endtask

   initial begin
      int v;
      bit saw_listo;
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      exp_c = 0; exp_d = 0; exp_u = 0;

      rst = 1'b1;
      bus.cargar  = 1'b0;
      bus.entrada = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ocupado", {31'd0, bus.ocupado}, 0);
      check("rst_listo", {31'd0, bus.listo}, 0);
      check("rst_digits", {20'd0, bus.centena, bus.decena, bus.unidad}, 0);
      check("rst_anodo", {29'd0, bus.anodo}, {29'd0, 3'b110});
      check("rst_seg", {25'd0, bus.segmentos}, {25'd0, 7'b1000000});
      rst = 1'b0;
      @(negedge clk);

      convert(255, 1'b0); scan_check();
      convert(0,   1'b0); scan_check();
      convert(100, 1'b0); scan_check();
      convert(7,   1'b0); scan_check();
      convert(42,  1'b1); scan_check();
      convert(99,  1'b0);

      // Reset in the middle of converting 200, with cargar also high
      bus.entrada = 8'd200;
      bus.cargar  = 1'b1;
      @(negedge clk);
      bus.cargar = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bus.cargar = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.cargar = 1'b0;
      exp_c = 0; exp_d = 0; exp_u = 0;
      check("midrst_ocupado", {31'd0, bus.ocupado}, 0);
      check("midrst_listo", {31'd0, bus.listo}, 0);
      check("midrst_digits", {20'd0, bus.centena, bus.decena, bus.unidad}, 0);
      check("midrst_anodo", {29'd0, bus.anodo}, {29'd0, 3'b110});
      saw_listo = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.listo) saw_listo = 1'b1;
      end
      check("midrst_no_listo", {31'd0, saw_listo}, 0);
      $display("reset mid-conversion, digits=%0d%0d%0d", bus.centena, bus.decena, bus.unidad);
      convert(200, 1'b0); scan_check();

      for (int i = 0; i < 16; i++) begin
         v = int'($urandom_range(0, 255));
         convert(v, 1'($urandom_range(0, 1)));
         if (i % 4 == 0) scan_check();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
